// File: rtl/tis100_pkg.sv
// Shared TIS-100 node constants and the program-loader state encoding.
package tis100_pkg;

    localparam int         INSTR_W   = 18;
    localparam int         ADDR_W    = 8;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN,
        ST_B0,
        ST_B1,
        ST_B2,
        ST_WR,
        ST_CK,
        ST_DONE,
        ST_ERR
    } ldr_state_e;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream program loader for the TIS-100 instruction memory; holds the core while loading.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CKSUM_EN.
module imem_loader #(
    parameter int         ADDR_W    = tis100_pkg::ADDR_W,
    parameter int         INSTR_W   = tis100_pkg::INSTR_W,
    parameter logic [7:0] SYNC_BYTE = tis100_pkg::SYNC_BYTE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [7:0]         s_data,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [INSTR_W-1:0] wr_data,
    output logic               core_hold,
    output logic               busy,
    output logic               done,
    output logic               err
);
    import tis100_pkg::*;

    ldr_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [1:0]         b0_q, b0_d;
    logic [7:0]         b1_q, b1_d;
    logic [INSTR_W-1:0] data_q, data_d;
    logic [7:0]         cksum_q, cksum_d;
    logic               hold_q, hold_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               accept;
    logic               sync_seen;

    // The only stall is the single write cycle; the memory port never backpressures.
    assign s_ready   = !rst && (state_q != ST_WR);
    assign accept    = s_valid && s_ready;
    assign sync_seen = accept && (s_data == SYNC_BYTE);

    assign wr_en     = (state_q == ST_WR);
    assign wr_addr   = addr_q;
    assign wr_data   = data_q;
    assign core_hold = hold_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        data_d  = data_q;
        cksum_d = cksum_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (sync_seen) begin
                    state_d = ST_LEN;
                    hold_d  = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    addr_d  = '0;
                    cksum_d = '0;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    if (s_data == 8'd0) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d   = s_data;
                        state_d = ST_B0;
                    end
                end
            end
            ST_B0: begin
                if (accept) begin
                    if (|s_data[7:2]) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        b0_d    = s_data[1:0];
                        cksum_d = cksum_q ^ s_data;
                        state_d = ST_B1;
                    end
                end
            end
            ST_B1: begin
                if (accept) begin
                    b1_d    = s_data;
                    cksum_d = cksum_q ^ s_data;
                    state_d = ST_B2;
                end
            end
            ST_B2: begin
                if (accept) begin
                    data_d  = {b0_q, b1_q, s_data};
                    cksum_d = cksum_q ^ s_data;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                addr_d = addr_q + 1'b1;
                cnt_d  = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
`ifdef IMEM_LOADER_CKSUM_EN
                    state_d = ST_CK;
`else
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    hold_d  = 1'b0;
`endif
                end else begin
                    state_d = ST_B0;
                end
            end
            ST_CK: begin
                if (accept) begin
                    if (s_data == cksum_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            b0_q    <= '0;
            b1_q    <= '0;
            data_q  <= '0;
            cksum_q <= '0;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            data_q  <= data_d;
            cksum_q <= cksum_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule
